// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared FSM state type and reference truth tables for gate_truth_checker
package gate_chk_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
endpackage

// File: rtl/gate_chk_settle_ctr.sv
// gate_chk_settle_ctr: loadable down-counter that flags its final settle cycle
module gate_chk_settle_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         last
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign last = cnt == W'(1);
endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps all input vectors of a gate and checks its output; GATE_CHK_CAPTURE_EN enables observed_tt capture
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [2**N_IN-1:0] EXPECT_TT = TT_NOR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dut_y,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      fail_idx,
  output logic [2**N_IN-1:0]   observed_tt
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES);
  state_t state;
  logic last, kick, mismatch, last_vec;
  assign kick = state == IDLE && start;
  assign last_vec = &stim;
  assign mismatch = dut_y != EXPECT_TT[stim];
  gate_chk_settle_ctr #(.W(CW)) u_ctr (
    .clk(clk),
    .rst(rst),
    .load(kick || (state == SAMPLE && !last_vec)),
    .dec(state == SETTLE && !last),
    .load_val(RELOAD),
    .last(last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      stim <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      fail_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          stim <= '0;
          err_count <= '0;
          fail_idx <= '0;
          pass <= 1'b0;
          busy <= 1'b1;
          state <= SETTLE;
        end
        SETTLE: if (last) state <= SAMPLE;
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) fail_idx <= stim;
          end
          if (last_vec) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= err_count == '0 && !mismatch;
          end else begin
            stim <= stim + 1'b1;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
`ifdef GATE_CHK_CAPTURE_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) observed_tt <= '0;
    else if (kick) observed_tt <= '0;
    else if (state == SAMPLE) observed_tt[stim] <= dut_y;
`else
  assign observed_tt = '0;
`endif
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: scoreboard bench for gate_truth_checker (2-input NOR sweep plus a 3-input fast-settle instance)
module tb_gate_truth_checker;
  import gate_chk_pkg::*;
  typedef struct {
    int p;
    int err;
    int fidx;
    int obs;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start3 = 1'b0;
  int mode = 0;
  logic dut_y, dut3_y;
  logic [1:0] stim;
  logic [2:0] stim3;
  logic busy, done, pass, busy3, done3, pass3;
  logic [2:0] err_count;
  logic [3:0] err3;
  logic [1:0] fail_idx;
  logic [2:0] fail3;
  logic [3:0] observed_tt;
  logic [7:0] obs3;
  int total = 0;
  int bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic int gate(input int m, input int i);
    return m == 0 ? int'(i == 0) : m == 1 ? 0 : int'(i != 0);
  endfunction

  assign dut_y = gate(mode, int'(stim)) != 0;
  assign dut3_y = ~|stim3;

  gate_truth_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_y(dut_y), .stim(stim), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .fail_idx(fail_idx), .observed_tt(observed_tt)
  );

  gate_truth_checker #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECT_TT(8'h01)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .dut_y(dut3_y), .stim(stim3), .busy(busy3),
    .done(done3), .pass(pass3), .err_count(err3), .fail_idx(fail3), .observed_tt(obs3)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stim"}, int'(stim), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_fidx"}, int'(fail_idx), 0);
    chk({tag, "_obs"}, int'(observed_tt), 0);
  endtask

  task automatic run(input int m, input bit repulse, input bit abort);
    exp_t e;
    int n;
    int seen;
    logic [3:0] tt;
    tt = TT_NOR;
    e = '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      int y;
      y = gate(m, i);
      e.obs |= y << i;
      if (y != int'(tt[i])) begin
        if (e.err == 0) e.fidx = i;
        e.err++;
      end
    end
    e.p = int'(e.err == 0);
`ifndef GATE_CHK_CAPTURE_EN
    e.obs = 0;
`endif
    sb.push_back(e);
    mode = m;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    chk("busy_on", int'(busy), 1);
    n = 0;
    while (!done && n < 100) begin
      if (n % 3 == 0 && n < 12) chk("stim_step", int'(stim), n / 3);
      start = repulse && (n == 2 || n == 11);
      if (abort && stim == 2'b10 && n % 3 == 1) begin
        rst = 1'b1;
        #1 check_zero("abort");
        @(negedge clk) rst = 1'b0;
        void'(sb.pop_back());
        seen = 0;
        for (int k = 0; k < 20; k++) @(negedge clk) seen |= int'(done);
        chk("abort_no_done", seen, 0);
        return;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_edge", n, 12);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pass", int'(pass), e.p);
      chk("err_count", int'(err_count), e.err);
      chk("fail_idx", int'(fail_idx), e.fidx);
      chk("observed_tt", int'(observed_tt), e.obs);
    end
    seen = 0;
    for (int k = 0; k < 4; k++) @(negedge clk) seen += int'(done);
    chk("done_once", seen, 0);
    chk("busy_off", int'(busy), 0);
    chk("stim_hold", int'(stim), 3);
  endtask

  initial begin
    int n;
    #1 check_zero("reset");
    @(negedge clk) rst = 1'b0;
    run(0, 0, 0);
    run(1, 0, 0);
    run(2, 0, 0);
    run(0, 1, 0);
    run(0, 0, 1);
    run(0, 0, 0);
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    n = 0;
    while (!done3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("n3_done_edge", n, 16);
    chk("n3_pass", int'(pass3), 1);
    chk("n3_err", int'(err3), 0);
    chk("n3_fidx", int'(fail3), 0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
